// File: rtl/seq_unsigned_multiplier.sv
// Sequential unsigned shift-add multiplier: A/C/Q/M datapath with an ADD/SHIFT
// controller, one partial-product add per multiplier bit, start/done handshake.
module seq_unsigned_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, q, m;
    logic             c;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic             last;

    assign sum  = {1'b0, a} + {1'b0, m};
    assign last = (count == CW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? DONE : ADD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Carry C is kept as a real register bit so the WIDTH+1-bit add never loses
    // its MSB; the following shift moves it into A's top bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a       <= '0;
            c       <= 1'b0;
            q       <= '0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m     <= multiplicand;
                    q     <= multiplier;
                    a     <= '0;
                    c     <= 1'b0;
                    count <= CW'(WIDTH);
                end
                ADD: if (q[0]) {c, a} <= sum;
                SHIFT: begin
                    {c, a, q} <= {1'b0, c, a, q[WIDTH-1:1]};
                    count     <= count - CW'(1);
                    if (last) product <= {c, a, q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_unsigned_multiplier.sv
// Directed bench: vector table on a WIDTH=8 instance plus hand sequences for
// busy-time starts, async reset abort and WIDTH=4 back-to-back issue.
module tb_seq_unsigned_multiplier;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  mcand8 = '0, mplier8 = '0;
    logic [15:0] product8;
    logic        busy8, done8;

    logic        start4 = 1'b0;
    logic [3:0]  mcand4 = '0, mplier4 = '0;
    logic [7:0]  product4;
    logic        busy4, done4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    seq_unsigned_multiplier #(.WIDTH(8)) dut8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start8),
        .multiplicand(mcand8), .multiplier(mplier8),
        .product(product8), .busy(busy8), .done(done8)
    );

    seq_unsigned_multiplier #(.WIDTH(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start4),
        .multiplicand(mcand4), .multiplier(mplier4),
        .product(product4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one W8 op and watch 30 edges: busy after accept, done edge/count, product.
    task automatic run8(input string name, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp);
        int first_done;
        int n_done;
        logic [15:0] p_at_done;
        first_done = -1;
        n_done     = 0;
        p_at_done  = 'x;
        @(negedge i_clk);
        start8 = 1'b1; mcand8 = m; mplier8 = q;
        @(posedge i_clk); #1;
        chk({name, " busy_after_accept"}, 32'(busy8), 32'd1);
        start8 = 1'b0; mcand8 = ~m; mplier8 = 8'h5A;
        for (int k = 1; k <= 30; k++) begin
            @(posedge i_clk); #1;
            if (done8) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    p_at_done  = product8;
                end
            end
        end
        chk({name, " done_edge"}, 32'(first_done), 32'd16);
        chk({name, " done_count"}, 32'(n_done), 32'd1);
        chk({name, " product"}, 32'(p_at_done), 32'(exp));
        chk({name, " product_hold"}, 32'(product8), 32'(exp));
        chk({name, " idle_busy"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        int n_done;
        int d_edge [2];
        logic [7:0] p4 [2];

        vecs[0] = '{m: 8'd13,  q: 8'd11,  p: 16'h008F};
        vecs[1] = '{m: 8'd255, q: 8'd255, p: 16'hFE01};
        vecs[2] = '{m: 8'd0,   q: 8'd200, p: 16'h0000};
        vecs[3] = '{m: 8'd200, q: 8'd0,   p: 16'h0000};
        vecs[4] = '{m: 8'd1,   q: 8'd1,   p: 16'h0001};
        vecs[5] = '{m: 8'd255, q: 8'd1,   p: 16'h00FF};
        vecs[6] = '{m: 8'd128, q: 8'd2,   p: 16'h0100};
        vecs[7] = '{m: 8'd1,   q: 8'd255, p: 16'h00FF};

        #12;
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset product", 32'(product8), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run8($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].p);

        // start and new operands while busy must be ignored and not queued
        @(negedge i_clk);
        start8 = 1'b1; mcand8 = 8'd6; mplier8 = 8'd7;
        @(posedge i_clk); #1;
        n_done = 0;
        d_edge[0] = -1;
        mcand8 = 8'd9; mplier8 = 8'd9;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (k == 6) start8 = 1'b0;
            if (done8) begin
                n_done++;
                if (d_edge[0] < 0) d_edge[0] = k;
            end
        end
        chk("busy_start done_count", 32'(n_done), 32'd1);
        chk("busy_start done_edge", 32'(d_edge[0]), 32'd16);
        chk("busy_start product", 32'(product8), 32'h002A);

        // async reset in SHIFT aborts without waiting for a clock
        @(negedge i_clk);
        start8 = 1'b1; mcand8 = 8'd100; mplier8 = 8'd3;
        @(posedge i_clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort product", 32'(product8), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run8("after_reset", 8'd5, 8'd5, 16'h0019);

        // WIDTH=4 back-to-back: 15*15 then 9*6, start held high across both
        @(negedge i_clk);
        start4 = 1'b1; mcand4 = 4'd15; mplier4 = 4'd15;
        @(posedge i_clk); #1;
        mcand4 = 4'd9; mplier4 = 4'd6;
        n_done = 0;
        d_edge[0] = -1; d_edge[1] = -1;
        p4[0] = 'x; p4[1] = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (k == 10) start4 = 1'b0;
            if (done4) begin
                if (n_done < 2) begin
                    d_edge[n_done] = k;
                    p4[n_done]     = product4;
                end
                n_done++;
            end
        end
        chk("w4 done_count", 32'(n_done), 32'd2);
        chk("w4 first_edge", 32'(d_edge[0]), 32'd8);
        chk("w4 spacing", 32'(d_edge[1] - d_edge[0]), 32'd10);
        chk("w4 product0", 32'(p4[0]), 32'hE1);
        chk("w4 product1", 32'(p4[1]), 32'h36);
        chk("w4 idle_busy", 32'(busy4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
